// File: rtl/fsmc_pkg.sv
// Shared types and helpers for the FSMC chip-select decoder.
// Board default map: TFT on code 00, reset register on 10, key scanner on 11.
package fsmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HOLDOFF
    } fsm_state_e;

    localparam logic [1:0] CODE_TFT = 2'b00;
    localparam logic [1:0] CODE_RST = 2'b10;
    localparam logic [1:0] CODE_KEY = 2'b11;

    localparam logic [5:0] BOARD_CODE_MAP = {CODE_KEY, CODE_RST, CODE_TFT};

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int idx_width(input int unsigned v);
        return (clog2(v) > 1) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Multi-bit synchroniser chain for asynchronous FSMC bus inputs.
// Resets to all-ones so the idle (inactive-high) bus levels appear at once.
module fsmc_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stg_q;
    logic [STAGES-1:0][W-1:0] stg_d;

    always_comb begin
        stg_d = {stg_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= '1;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/fsmc_cs_decoder.sv
// Chip-select decoder for the STM32F4 FSMC multiplexed bus, clocked by the
// FPGA system clock: latches the code on NADV rise, holds until NE or timeout.
module fsmc_cs_decoder
    import fsmc_pkg::*;
#(
    parameter int                NCH         = 3,
    parameter int                DW          = 2,
    parameter logic [NCH*DW-1:0] CODE_MAP    = BOARD_CODE_MAP,
    parameter int                SYNC_STAGES = 2,
    parameter int                TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      nadv,
    input  logic                      ne_n,
    input  logic                      bank_n,
    input  logic [DW-1:0]             code,
    output logic [NCH-1:0]            cs_n,
    output logic                      active,
    output logic [idx_width(NCH)-1:0] hit_idx,
    output logic                      miss_pulse,
    output logic                      timeout_pulse
);

    localparam int HW = idx_width(NCH);
    localparam int CW = idx_width(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [DW+2:0] sync_q;
    logic          s_nadv;
    logic          s_ne;
    logic          s_bank;
    logic [DW-1:0] s_code;

    fsmc_sync #(
        .W      (DW + 3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({nadv, ne_n, bank_n, code}),
        .q   (sync_q)
    );

    assign {s_nadv, s_ne, s_bank, s_code} = sync_q;

    fsm_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] cs_n_q, cs_n_d;
    logic [HW-1:0]  hit_q, hit_d;
    logic           act_q, act_d;
    logic           miss_q, miss_d;
    logic           tmo_q, tmo_d;
    logic           prev_q, prev_d;
    logic           ale_q, ale_d;
    logic [DW-1:0]  code_q, code_d;
    logic           bank_q, bank_d;

    logic           dec_hit;
    logic [HW-1:0]  dec_idx;
    logic           at_limit;

    // Downward scan so the lowest matching channel is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (code_q == CODE_MAP[i*DW +: DW]) begin
                dec_hit = 1'b1;
                dec_idx = HW'(i);
            end
        end
        if (bank_q) begin
            dec_hit = 1'b0;
            dec_idx = '0;
        end
    end

    assign at_limit = (TIMEOUT != 0) && (32'(cnt_q) == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        hit_d   = hit_q;
        act_d   = act_q;
        miss_d  = 1'b0;
        tmo_d   = 1'b0;
        prev_d  = s_nadv;
        ale_d   = s_nadv & ~prev_q;
        code_d  = s_code;
        bank_d  = s_bank;

        unique case (state_q)
            ST_IDLE: begin
                cs_n_d = '1;
                act_d  = 1'b0;
                hit_d  = '0;
                cnt_d  = '0;
                if (ale_q) begin
                    if (dec_hit) begin
                        cs_n_d  = ~(NCH'(1) << dec_idx);
                        act_d   = 1'b1;
                        hit_d   = dec_idx;
                        state_d = ST_ACTIVE;
                    end else begin
                        miss_d = ~bank_q;
                    end
                end
            end
            ST_ACTIVE: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                if (s_ne) begin
                    cs_n_d  = '1;
                    act_d   = 1'b0;
                    hit_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (ale_q) begin
                    if (dec_hit) begin
                        cs_n_d = ~(NCH'(1) << dec_idx);
                        hit_d  = dec_idx;
                        cnt_d  = '0;
                    end else begin
                        cs_n_d  = '1;
                        act_d   = 1'b0;
                        hit_d   = '0;
                        cnt_d   = '0;
                        miss_d  = ~bank_q;
                        state_d = ST_IDLE;
                    end
                end else if (at_limit) begin
                    cs_n_d  = '1;
                    act_d   = 1'b0;
                    hit_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // A stuck access must finish before any new decode.
                cs_n_d = '1;
                act_d  = 1'b0;
                hit_d  = '0;
                cnt_d  = '0;
                if (s_ne) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_n_d  = '1;
                act_d   = 1'b0;
                hit_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= '1;
            hit_q   <= '0;
            act_q   <= 1'b0;
            miss_q  <= 1'b0;
            tmo_q   <= 1'b0;
            prev_q  <= 1'b1;
            ale_q   <= 1'b0;
            code_q  <= '1;
            bank_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            hit_q   <= hit_d;
            act_q   <= act_d;
            miss_q  <= miss_d;
            tmo_q   <= tmo_d;
            prev_q  <= prev_d;
            ale_q   <= ale_d;
            code_q  <= code_d;
            bank_q  <= bank_d;
        end
    end

    assign cs_n          = cs_n_q;
    assign active        = act_q;
    assign hit_idx       = hit_q;
    assign miss_pulse    = miss_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_fsmc_cs_decoder.sv
// Directed and random bench for fsmc_cs_decoder: three instances covering
// default map, short watchdog, and a five-channel map with the watchdog off.
module tb_fsmc_cs_decoder;

    localparam int SS = 2;
    localparam logic [14:0] MAP2 = {3'd5, 3'd0, 3'd6, 3'd3, 3'd1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       nadv   [3];
    logic       ne_n   [3];
    logic       bank_n [3];
    logic [2:0] code   [3];

    logic [2:0] cs0, cs1;
    logic [4:0] cs2;
    logic       act  [3];
    logic [1:0] hi0, hi1;
    logic [2:0] hi2;
    logic       miss [3];
    logic       tmo  [3];

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    fsmc_cs_decoder d0 (
        .clk(clk), .rst(rst), .nadv(nadv[0]), .ne_n(ne_n[0]),
        .bank_n(bank_n[0]), .code(code[0][1:0]), .cs_n(cs0),
        .active(act[0]), .hit_idx(hi0), .miss_pulse(miss[0]),
        .timeout_pulse(tmo[0])
    );

    fsmc_cs_decoder #(.TIMEOUT(8)) d1 (
        .clk(clk), .rst(rst), .nadv(nadv[1]), .ne_n(ne_n[1]),
        .bank_n(bank_n[1]), .code(code[1][1:0]), .cs_n(cs1),
        .active(act[1]), .hit_idx(hi1), .miss_pulse(miss[1]),
        .timeout_pulse(tmo[1])
    );

    fsmc_cs_decoder #(
        .NCH(5), .DW(3), .CODE_MAP(MAP2), .TIMEOUT(0)
    ) d2 (
        .clk(clk), .rst(rst), .nadv(nadv[2]), .ne_n(ne_n[2]),
        .bank_n(bank_n[2]), .code(code[2]), .cs_n(cs2),
        .active(act[2]), .hit_idx(hi2), .miss_pulse(miss[2]),
        .timeout_pulse(tmo[2])
    );

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
            return;
        end
        exp = sb.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int u, input bit b, input logic [2:0] c);
        step();
        bank_n[u] = b;
        code[u]   = c;
        ne_n[u]   = 1'b0;
        nadv[u]   = 1'b0;
        step();
        nadv[u]   = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($countones(~cs0) <= 1 && $countones(~cs1) <= 1
                    && $countones(~cs2) <= 1) else begin
                errors++;
                $error("FAIL onehot observed=%b/%b/%b expected at most one low",
                       cs0, cs1, cs2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=stall expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [14:0] map2;
        logic [4:0]  ecs;
        logic [2:0]  ehi;
        bit          b;
        logic [2:0]  c;

        map2 = MAP2;
        for (int u = 0; u < 3; u++) begin
            nadv[u] = 1'b1; ne_n[u] = 1'b1; bank_n[u] = 1'b1; code[u] = '0;
        end
        step(3);
        rst = 1'b0;
        step(2);

        push(3'b111); cmp("rst_cs", cs0);
        push(0);      cmp("rst_active", act[0]);
        push(0);      cmp("rst_hit", hi0);
        push(0);      cmp("rst_miss", miss[0]);
        push(0);      cmp("rst_tmo", tmo[0]);

        pulse(0, 1'b0, 3'b000);
        step(SS + 1);
        push(3'b111); cmp("lat_early", cs0);
        step();
        push(3'b110); cmp("lat_cs", cs0);
        push(1);      cmp("lat_active", act[0]);
        push(0);      cmp("lat_hit", hi0);
        step();
        ne_n[0] = 1'b1;
        step(SS);
        push(3'b110); cmp("rel_early", cs0);
        step();
        push(3'b111); cmp("rel_cs", cs0);
        push(0);      cmp("rel_active", act[0]);

        pulse(0, 1'b0, 3'b001);
        step(SS + 2);
        push(3'b111); cmp("miss_cs", cs0);
        push(1);      cmp("miss_pulse", miss[0]);
        step();
        push(0);      cmp("miss_one_cycle", miss[0]);
        pulse(0, 1'b1, 3'b001);
        step(SS + 2);
        push(0);      cmp("bank_silent", miss[0]);
        step();
        push(0);      cmp("bank_silent2", miss[0]);
        push(3'b111); cmp("bank_cs", cs0);

        pulse(0, 1'b0, 3'b010);
        step(SS + 2);
        push(3'b101); cmp("b2b_first", cs0);
        push(1);      cmp("b2b_hit1", hi0);
        pulse(0, 1'b0, 3'b011);
        for (int k = 0; k < SS + 1; k++) begin
            step();
            push(3'b101); cmp("b2b_hold", cs0);
        end
        step();
        push(3'b011); cmp("b2b_switch", cs0);
        push(2);      cmp("b2b_hit2", hi0);
        push(1);      cmp("b2b_active", act[0]);
        step();
        ne_n[0] = 1'b1;
        step(SS + 1);
        push(3'b111); cmp("b2b_rel", cs0);

        pulse(1, 1'b0, 3'b011);
        step(SS + 2);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) step();
            push(3'b011); cmp("to_hold", cs1);
        end
        step();
        push(3'b111); cmp("to_release", cs1);
        push(1);      cmp("to_pulse", tmo[1]);
        push(0);      cmp("to_active", act[1]);
        step();
        push(0);      cmp("to_pulse_end", tmo[1]);
        pulse(1, 1'b0, 3'b011);
        step(SS + 4);
        push(3'b111); cmp("holdoff_ignore", cs1);
        push(0);      cmp("holdoff_active", act[1]);
        ne_n[1] = 1'b1;
        step(SS + 2);
        pulse(1, 1'b0, 3'b000);
        step(SS + 2);
        push(3'b110); cmp("to_next", cs1);
        step();
        ne_n[1] = 1'b1;
        step(SS + 2);

        pulse(0, 1'b0, 3'b000);
        step(SS + 2);
        push(3'b110); cmp("pre_rst", cs0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        push(3'b111); cmp("async_rst_cs", cs0);
        push(0);      cmp("async_rst_act", act[0]);
        step();
        rst = 1'b0;
        step(6);
        push(3'b111); cmp("post_rst_cs", cs0);
        push(0);      cmp("post_rst_act", act[0]);
        pulse(0, 1'b0, 3'b000);
        step(SS + 2);
        push(3'b110); cmp("post_rst_access", cs0);
        step();
        ne_n[0] = 1'b1;
        step(SS + 2);

        for (int n = 0; n < 1000; n++) begin
            b = ($urandom_range(0, 7) == 0);
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                step();
                ne_n[2] = 1'b1;
                step(SS + 1);
                push(5'h1f); cmp("rnd_release", cs2);
            end
            ecs = 5'h1f;
            ehi = '0;
            if (!b) begin
                for (int i = 0; i < 5; i++) begin
                    if (map2[i*3 +: 3] == c) begin
                        ecs = ~(5'd1 << i);
                        ehi = 3'(i);
                    end
                end
            end
            push(ecs);
            push(ehi);
            push((!b && ecs == 5'h1f) ? 1 : 0);
            push((ecs != 5'h1f) ? 1 : 0);
            pulse(2, b, c);
            step(SS + 2);
            cmp("rnd_cs", cs2);
            cmp("rnd_hit", hi2);
            cmp("rnd_miss", miss[2]);
            cmp("rnd_active", act[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsmc_cs_decoder.md
Name: fsmc_cs_decoder

Overview:
- Clocked, parametrised chip-select decoder for the STM32F4 FSMC multiplexed bus.
- Samples the decode address lines at the end of the address phase (NADV rising) and drives one active-low chip select per FPGA peripheral (TFT, reset register, key scanner, ...).
- Holds the select until the FSMC bank enable NE releases, or until a watchdog timeout expires.
- Supersedes the NADV-clocked three-select decoder: all logic runs on the FPGA system clock with synchronised bus inputs.

Parameters:
- NCH, 3, number of chip-select channels (1..8)
- DW, 2, width of decode code (address lines used for decode)
- CODE_MAP, {2'b11,2'b10,2'b00}, flat NCH*DW vector; slice i is the code selecting channel i; codes must be distinct
- SYNC_STAGES, 2, synchroniser depth for bus inputs (>=2)
- TIMEOUT, 255, max cycles a select may stay asserted; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- nadv  in  1  FSMC address-valid, active-low, async to clk
- ne_n  in  1  FSMC bank enable, active-low, async to clk
- bank_n  in  1  bank-qualify address line (old a16); decode only when 0
- code  in  DW  decode address lines (old {da2,da1})
- cs_n  out  NCH  registered chip selects, active-low, at most one low
- active  out  1  a select is currently asserted
- hit_idx  out  clog2(NCH) max 1  index of the asserted channel; 0 when idle
- miss_pulse  out  1  one-cycle pulse: qualified decode matched no channel
- timeout_pulse  out  1  one-cycle pulse: watchdog released a select

Behaviour:
- Reset (async, active-high): cs_n all 1, active 0, hit_idx 0, both pulses 0, FSM IDLE, counter 0, synchroniser stages all 1.
- nadv, ne_n, bank_n and code each pass through SYNC_STAGES flops. code and bank_n are sampled from the same stage as nadv.
- Address latch event (ale): synchronised nadv was 0 last cycle and is 1 this cycle.
- Decode on ale:
  - If bank_n==1: no match.
  - Otherwise, match channel i when code==CODE_MAP[i].
  - If several slices are equal, the lowest index wins.
- FSM states: IDLE, ACTIVE, HOLDOFF.
- IDLE, on ale:
  - Match i: next cycle cs_n[i]=0, active=1, hit_idx=i, counter=0, go to ACTIVE.
  - No match with bank_n==0: miss_pulse=1 for one cycle, stay IDLE.
  - No match with bank_n==1: silent.
- ACTIVE:
  - Counter increments each cycle and saturates.
  - Synchronised ne_n==1: next cycle all cs_n=1, active=0, hit_idx=0, go to IDLE.
  - Counter reaches TIMEOUT-1 (TIMEOUT!=0): next cycle all cs_n=1, active=0, timeout_pulse=1, go to HOLDOFF.
  - New ale (back-to-back access, NE held low): re-decode with IDLE rules. A match switches cs_n directly to the new channel in one cycle (never two lows) and clears the counter. A miss releases to IDLE and pulses miss_pulse.
  - Priority when events coincide: ne_n release > ale > timeout.
- HOLDOFF: all selects high. Wait for synchronised ne_n==1, then go to IDLE. ale is ignored here; an access stuck past the timeout must end before a new decode.
- Latency: ale detected in cycle k -> cs_n valid at the end of cycle k. Measured from the nadv pin, the total is SYNC_STAGES+2 clk edges.
- The counter width is clog2(TIMEOUT+1). Counter and TIMEOUT comparisons are unsigned.
- Reset asserted mid-access: outputs go to reset values immediately. After reset release, no select is asserted until the next ale.

Decomposition:
- Package fsmc_pkg holds:
  - FSM state enum (IDLE, ACTIVE, HOLDOFF)
  - a clog2 helper function
  - default CODE_MAP constants for the TFT/RST/KEY board
- Sub-module fsmc_sync: parametrised multi-bit synchroniser, SYNC_STAGES deep, async reset to all-ones, instantiated once for {nadv, ne_n, bank_n, code}.

Test Plan:
- Default params, bank_n=0, code=2'b00, pulse nadv low->high, ne_n low -> cs_n=3'b110 exactly SYNC_STAGES+2 edges after nadv rise; ne_n high -> cs_n=3'b111 and active=0 within SYNC_STAGES+1 edges.
- code=2'b01, bank_n=0, nadv pulse -> cs_n stays 3'b111, miss_pulse high one cycle; repeat with bank_n=1 -> no miss_pulse.
- code=2'b10 asserted (cs_n=3'b101), then second nadv pulse with code=2'b11 while ne_n low -> cs_n goes 3'b101 -> 3'b011 in one cycle, never two zeros, hit_idx 1->2.
- TIMEOUT=8, ne_n held low after decode of 2'b11 -> cs_n[2] low for exactly 8 cycles, then 3'b111 with timeout_pulse one cycle; extra nadv pulse ignored until ne_n high; next access decodes normally.
- Reset asserted while cs_n=3'b110 -> cs_n=3'b111 asynchronously (before next clk edge); after release, nothing asserts until a fresh nadv rise.
- NCH=5, DW=3, random CODE_MAP with distinct codes, 1000 random accesses -> cs_n checked against a reference model; one-hot-or-none invariant holds every cycle.
